// File: rtl/instr_sequencer_if.sv
// Control bus between the instruction sequencer (master) and the datapath/memory side (slave).
interface instr_sequencer_if;
  logic       run;
  logic [3:0] opcode;
  logic       flag_c;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       mem_enable;
  logic       mem_read;
  logic       mem_write;
  logic       mem_reg;
  logic       reg_write;
  logic       reg_dst;
  logic       ALU_src;
  logic [3:0] ALU_op;
  logic       branch;
  logic       flag_write;
  logic       instr_done;
  logic       bus_err;
  logic [2:0] state;

  modport master (
    input  run, opcode, flag_c, mem_ready,
    output pc_write, ir_write, mem_enable, mem_read, mem_write, mem_reg, reg_write, reg_dst,
           ALU_src, ALU_op, branch, flag_write, instr_done, bus_err, state
  );

  modport slave (
    output run, opcode, flag_c, mem_ready,
    input  pc_write, ir_write, mem_enable, mem_read, mem_write, mem_reg, reg_write, reg_dst,
           ALU_src, ALU_op, branch, flag_write, instr_done, bus_err, state
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM driving state-qualified datapath strobes,
// with a memory wait-state timeout that parks the sequencer in a sticky error state.
module instr_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned WAIT_W       = 4
) (
  input logic               clk,
  input logic               rst,
  instr_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StErr    = 3'd6
  } state_e;

  state_e            r_state, w_state_d, w_next;
  logic [3:0]        r_op, w_op_d;
  logic [WAIT_W-1:0] r_wait, w_wait_d;
  logic              r_bus_err, w_bus_err_d;
  logic              w_store, w_load, w_br, w_cmp, w_timeout;

  always_comb begin
    w_store   = r_op inside {4'd0, 4'd7, 4'd13};
    w_load    = r_op inside {4'd1, 4'd6, 4'd8, 4'd14};
    w_br      = r_op inside {4'd10, 4'd12};
    w_cmp     = (r_op == 4'd3);
    // Last counted wait cycle: a missing mem_ready here is fatal, a present one still wins.
    w_timeout = (r_wait == WAIT_W'(MEM_WAIT_MAX - 1));
    w_next    = bus.run ? StFetch : StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_op      <= '0;
      r_wait    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_op      <= w_op_d;
      r_wait    <= w_wait_d;
      r_bus_err <= w_bus_err_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_op_d      = r_op;
    w_bus_err_d = r_bus_err;
    w_wait_d    = '0;
    if ((r_state == StFetch || r_state == StMem) && !bus.mem_ready) begin
      w_wait_d = r_wait + 1'b1;
    end
    unique case (r_state)
      StIdle:   if (bus.run) w_state_d = StFetch;
      StFetch: begin
        if (bus.mem_ready) begin
          w_state_d = StDecode;
        end else if (w_timeout) begin
          w_state_d   = StErr;
          w_bus_err_d = 1'b1;
        end
      end
      StDecode: begin
        w_op_d    = bus.opcode;
        w_state_d = StExec;
      end
      StExec: begin
        if (w_cmp || w_br)         w_state_d = w_next;
        else if (w_store || w_load) w_state_d = StMem;
        else                        w_state_d = StWb;
      end
      StMem: begin
        if (bus.mem_ready) begin
          w_state_d = w_store ? w_next : StWb;
        end else if (w_timeout) begin
          w_state_d   = StErr;
          w_bus_err_d = 1'b1;
        end
      end
      StWb:     w_state_d = w_next;
      StErr:    w_state_d = StErr;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_enable = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_reg    = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.ALU_src    = 1'b0;
    bus.ALU_op     = 4'd0;
    bus.branch     = 1'b0;
    bus.flag_write = 1'b0;
    bus.instr_done = 1'b0;
    unique case (r_state)
      StFetch: begin
        bus.mem_enable = 1'b1;
        bus.mem_read   = 1'b1;
        bus.ir_write   = bus.mem_ready;
        bus.pc_write   = bus.mem_ready;
      end
      StExec: begin
        bus.ALU_op  = r_op;
        bus.ALU_src = r_op inside {4'd2, 4'd4, 4'd9, 4'd15};
        bus.reg_dst = r_op inside {4'd4, 4'd5, 4'd11, 4'd15};
        if (w_cmp) begin
          bus.flag_write = 1'b1;
          bus.instr_done = 1'b1;
        end else if (w_br) begin
          bus.branch     = 1'b1;
          bus.pc_write   = (r_op == 4'd10) || (r_op == 4'd12 && bus.flag_c);
          bus.instr_done = 1'b1;
        end
      end
      StMem: begin
        bus.ALU_op     = r_op;
        bus.mem_enable = 1'b1;
        bus.mem_write  = w_store;
        bus.mem_read   = w_load;
        bus.instr_done = w_store && bus.mem_ready;
      end
      StWb: begin
        // Destination select is held through the write cycle so it qualifies reg_write.
        bus.ALU_op     = r_op;
        bus.reg_write  = 1'b1;
        bus.mem_reg    = w_load;
        bus.reg_dst    = r_op inside {4'd4, 4'd5, 4'd11, 4'd15};
        bus.flag_write = r_op inside {4'd4, 4'd11, 4'd15};
        bus.instr_done = 1'b1;
      end
      default: ;
    endcase
    bus.bus_err = r_bus_err;
    bus.state   = r_state;
  end

endmodule
